// File: rtl/imem_port_arbiter_if.sv
// Instruction RAM port bundle: CPU fetch (read), loader (write), RAM side.
// slave = arbiter side; master = requesters and RAM side.
interface imem_port_arbiter_if #(
    parameter int WORD_AW = 10
);
    logic               if_req;
    logic [31:0]        if_addr;
    logic [31:0]        if_rdata;
    logic               if_rvalid;
    logic               ld_req;
    logic [31:0]        ld_addr;
    logic [31:0]        ld_wdata;
    logic               ld_ack;
    logic               mem_en;
    logic               mem_we;
    logic [WORD_AW-1:0] mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               err_oor;

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr,
        input  ld_wdata, mem_rdata,
        output if_rdata, if_rvalid, ld_ack,
        output mem_en, mem_we, mem_addr,
        output mem_wdata, err_oor
    );

    modport master (
        output if_req, if_addr, ld_req, ld_addr,
        output ld_wdata, mem_rdata,
        input  if_rdata, if_rvalid, ld_ack,
        input  mem_en, mem_we, mem_addr,
        input  mem_wdata, err_oor
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction RAM between fetch and loader.
// Ports: clk, reset (sync, active-high), bus (imem_port_arbiter_if.slave).
module imem_port_arbiter #(
    parameter int          WORD_AW    = 10,
    parameter int          MEM_DEPTH  = 1001,
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_port_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_DONE
    } state_t;

    state_t             r_state;
    logic [SW-1:0]      r_starve;
    logic               r_rd_oor;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [WORD_AW-1:0] r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_ld_ack;
    logic               r_if_rvalid;
    logic [31:0]        r_if_rdata;
    logic               r_err_oor;

    logic               w_if_oor;
    logic               w_ld_oor;
    logic               w_fetch_win;
    logic               w_unused;

    assign w_if_oor = {2'b00, bus.if_addr[31:2]} >= 32'(MEM_DEPTH);
    assign w_ld_oor = {2'b00, bus.ld_addr[31:2]} >= 32'(MEM_DEPTH);
    assign w_unused = ^{bus.if_addr[1:0], bus.ld_addr[1:0]};

    // Loader wins ties until fetch has lost STARVE_MAX in a row.
    assign w_fetch_win = bus.if_req &&
        (!bus.ld_req || r_starve == SW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_starve    <= '0;
            r_rd_oor    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ld_ack    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_err_oor   <= 1'b0;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_ld_ack    <= 1'b0;
            r_if_rvalid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_fetch_win) begin
                        r_state  <= S_RD_ISSUE;
                        r_starve <= '0;
                        r_rd_oor <= w_if_oor;
                        if (w_if_oor) begin
                            r_err_oor <= 1'b1;
                        end else begin
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= bus.if_addr[WORD_AW+1:2];
                        end
                    end else if (bus.ld_req) begin
                        r_state  <= S_WR;
                        r_ld_ack <= 1'b1;
                        if (bus.if_req)
                            r_starve <= r_starve + 1'b1;
                        if (w_ld_oor) begin
                            r_err_oor <= 1'b1;
                        end else begin
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= bus.ld_addr[WORD_AW+1:2];
                            r_mem_wdata <= bus.ld_wdata;
                        end
                    end
                end
                S_WR:       r_state <= S_IDLE;
                S_RD_ISSUE: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_if_rdata  <= r_rd_oor ? NOP_INSTR
                                            : bus.mem_rdata;
                    r_if_rvalid <= 1'b1;
                    r_state     <= S_RD_DONE;
                end
                S_RD_DONE:  r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.ld_ack    = r_ld_ack;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.err_oor   = r_err_oor;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural RAM.
// Covers reset, fetch, write, starvation guard, out-of-range, mid-op reset.
module tb_imem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.WORD_AW(10)) bus ();

    imem_port_arbiter #(
        .WORD_AW   (10),
        .MEM_DEPTH (1001),
        .STARVE_MAX(4),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [31:0] ram [0:1023];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we)
                ram[bus.mem_addr] <= bus.mem_wdata;
            else
                bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a,
                         input logic [31:0] exp,
                         input string tag);
        int n;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.if_rvalid && n < 20);
        chk({tag, "_rv"}, 32'(bus.if_rvalid), 32'd1);
        chk({tag, "_lat"}, n, 32'd3);
        chk({tag, "_data"}, bus.if_rdata, exp);
        bus.if_req = 1'b0;
        step();
        chk({tag, "_rv_off"}, 32'(bus.if_rvalid), 32'd0);
    endtask

    initial begin
        string      sx;
        logic [7:0] ev [10];
        int         e;
        int         cyc;

        for (int i = 0; i < 1024; i++) ram[i] = i;
        ram[4] = 32'hDEAD_BEEF;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ld_req   = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_wdata = '0;
        bus.mem_rdata = '0;

        // 1: reset
        reset = 1'b1;
        repeat (3) step();
        chk("rst_en", 32'(bus.mem_en), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_ack", 32'(bus.ld_ack), 0);
        chk("rst_rv", 32'(bus.if_rvalid), 0);
        chk("rst_rdata", bus.if_rdata, 0);
        chk("rst_err", 32'(bus.err_oor), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("idle_en%0d", i),
                32'(bus.mem_en), 0);
        end

        // 2: fetch word 4
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        step();
        chk("f_en", 32'(bus.mem_en), 1);
        chk("f_we", 32'(bus.mem_we), 0);
        chk("f_addr", 32'(bus.mem_addr), 4);
        step();
        chk("f_en_off", 32'(bus.mem_en), 0);
        chk("f_rv_early", 32'(bus.if_rvalid), 0);
        step();
        chk("f_rv", 32'(bus.if_rvalid), 1);
        chk("f_data", bus.if_rdata, 32'hDEAD_BEEF);
        bus.if_req = 1'b0;
        step();
        chk("f_rv_off", 32'(bus.if_rvalid), 0);
        chk("f_hold", bus.if_rdata, 32'hDEAD_BEEF);

        // 3: loader write then readback
        bus.ld_req   = 1'b1;
        bus.ld_addr  = 32'h20;
        bus.ld_wdata = 32'h1234_5678;
        step();
        chk("w_en", 32'(bus.mem_en), 1);
        chk("w_we", 32'(bus.mem_we), 1);
        chk("w_ack", 32'(bus.ld_ack), 1);
        chk("w_addr", 32'(bus.mem_addr), 8);
        chk("w_wdata", bus.mem_wdata, 32'h1234_5678);
        bus.ld_req = 1'b0;
        step();
        chk("w_ack_off", 32'(bus.ld_ack), 0);
        chk("w_ram", ram[8], 32'h1234_5678);
        fetch(32'h20, 32'h1234_5678, "rb");

        // 4: starvation guard
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h10;
        bus.ld_req   = 1'b1;
        bus.ld_addr  = 32'h40;
        bus.ld_wdata = 32'hCAFE_0001;
        e   = 0;
        cyc = 0;
        while (e < 10 && cyc < 200) begin
            step();
            cyc++;
            if (bus.ld_ack) begin
                ev[e] = "L";
                e++;
            end
            if (bus.if_rvalid) begin
                ev[e] = "F";
                e++;
                chk("st_data", bus.if_rdata, 32'hDEAD_BEEF);
            end
        end
        bus.if_req = 1'b0;
        bus.ld_req = 1'b0;
        chk("st_events", e, 10);
        sx = "LLLLFLLLLF";
        for (int i = 0; i < 10; i++)
            chk($sformatf("st_seq%0d", i),
                32'(ev[i]), 32'(sx[i]));
        step();
        step();
        chk("st_quiet_ack", 32'(bus.ld_ack), 0);
        chk("st_ram", ram[16], 32'hCAFE_0001);

        // 5: out of range and boundary
        fetch(32'hFA0, 32'd1000, "last");
        chk("err_pre", 32'(bus.err_oor), 0);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'hFA4;
        step();
        chk("oor_f_en", 32'(bus.mem_en), 0);
        chk("oor_f_err", 32'(bus.err_oor), 1);
        step();
        step();
        chk("oor_f_rv", 32'(bus.if_rvalid), 1);
        chk("oor_f_nop", bus.if_rdata, 32'h0000_0013);
        bus.if_req = 1'b0;
        step();
        bus.ld_req   = 1'b1;
        bus.ld_addr  = 32'hFA4;
        bus.ld_wdata = 32'hBAD0_BAD0;
        step();
        chk("oor_w_ack", 32'(bus.ld_ack), 1);
        chk("oor_w_en", 32'(bus.mem_en), 0);
        chk("oor_w_we", 32'(bus.mem_we), 0);
        bus.ld_req = 1'b0;
        repeat (3) step();
        chk("oor_sticky", 32'(bus.err_oor), 1);

        // 6: reset in the middle of a fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        step();
        step();
        reset      = 1'b1;
        bus.if_req = 1'b0;
        step();
        chk("mr_rv", 32'(bus.if_rvalid), 0);
        chk("mr_rdata", bus.if_rdata, 0);
        chk("mr_err", 32'(bus.err_oor), 0);
        chk("mr_en", 32'(bus.mem_en), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mr_quiet%0d", i),
                32'(bus.if_rvalid), 0);
        end
        fetch(32'h20, 32'h1234_5678, "post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
